// File: rtl/intr_sched.sv
// intr_sched: edge-triggered, masked, fixed-priority interrupt scheduler with ireq/iack handshake.
// Define INTR_NESTING_EN to let a higher-priority source be offered while a lower one is in service.
module intr_sched #(
    parameter int NSRC = 4,
    parameter int VEC_W = $clog2(NSRC + 1),
    parameter logic [NSRC-1:0] MASK_INIT = {NSRC{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  irq,
    input  logic             gie,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_wdata,
    input  logic             iack,
    input  logic             eoi,
    output logic             ireq,
    output logic [VEC_W-1:0] ivec,
    output logic [NSRC-1:0]  mask,
    output logic [NSRC-1:0]  pending,
    output logic [NSRC-1:0]  in_service
);
    localparam int IW = NSRC > 1 ? $clog2(NSRC) : 1;
    typedef enum logic {IDLE, REQ} state_t;
    state_t state;
    logic [NSRC-1:0] irq_r, above, elig, taken, is_low;
    logic [IW-1:0] win, w;
    always_comb begin
        above = '1;
`ifdef INTR_NESTING_EN
        for (int i = 0; i < NSRC; i++) above[i] = ~|(in_service & ~({NSRC{1'b1}} << (i + 1)));
`else
        above = in_service == '0 ? '1 : '0;
`endif
        elig = pending & ~mask & above;
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) win = IW'(i);
        taken = (state == REQ && iack) ? NSRC'(1) << w : '0;
        is_low = eoi ? in_service & (~in_service + NSRC'(1)) : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_r      <= '0;
            pending    <= '0;
            in_service <= '0;
            mask       <= MASK_INIT;
            state      <= IDLE;
            w          <= '0;
            ireq       <= 1'b0;
            ivec       <= '0;
        end else begin
            irq_r      <= irq;
            pending    <= (pending & ~taken) | (irq & ~irq_r);
            in_service <= (in_service & ~is_low) | taken;
            if (mask_we) mask <= mask_wdata;
            // The offered vector stays frozen in REQ; only ack or loss of eligibility leaves it
            if (state == IDLE) begin
                if (gie && |elig) begin
                    state <= REQ;
                    w     <= win;
                    ireq  <= 1'b1;
                    ivec  <= VEC_W'(win) + VEC_W'(1);
                end
            end else if (iack || !gie || !elig[w]) begin
                state <= IDLE;
                ireq  <= 1'b0;
                ivec  <= '0;
            end
        end
    end
endmodule
